// File: rtl/rsa_exp_ctrl.sv
// rsa_exp_ctrl: computes y^d mod n with right-to-left square-and-multiply.
// One external Montgomery multiplier (MontAlg) is shared between the multiply
// and square steps, with at most one operation in flight.
// The accumulator m starts at plain 1 and t arrives in Montgomery form, so
// each MontMul(m, t) keeps m in the plain domain. The final m is y^d mod n
// and needs no conversion back.
// Optional feature macro: RSA_EXP_EARLY_EXIT_EN. When it is defined, the
// block stops as soon as no set exponent bits remain. When it is undefined,
// the block always performs EXP_BITS squarings.
module rsa_exp_ctrl #(
    parameter int WIDTH    = 256,
    parameter int EXP_BITS = 256
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [WIDTH-1:0]    i_n,
    input  logic [WIDTH-1:0]    i_t,
    input  logic [EXP_BITS-1:0] i_d,
    output logic                o_busy,
    output logic                o_done,
    output logic [WIDTH-1:0]    o_result,
    output logic                o_ma_start,
    output logic [WIDTH-1:0]    o_ma_n,
    output logic [WIDTH-1:0]    o_ma_a,
    output logic [WIDTH-1:0]    o_ma_b,
    input  logic [WIDTH-1:0]    i_ma_result,
    input  logic                i_ma_end
);

    localparam int CW = $clog2(EXP_BITS + 1);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        MUL_REQ,
        MUL_WAIT,
        SQR_REQ,
        SQR_WAIT,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      m_q, m_d;
    logic [WIDTH-1:0]      t_q, t_d;
    logic [WIDTH-1:0]      n_q, n_d;
    logic [EXP_BITS-1:0]   d_q, d_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]      res_q, res_d;
    logic                  fin;

`ifdef RSA_EXP_EARLY_EXIT_EN
    // Stop once no set exponent bits remain; trailing zeros cost nothing.
    assign fin = (d_q == '0) || (cnt_q == CW'(EXP_BITS));
`else
    // Always walk every exponent bit so the squaring count never depends on d.
    assign fin = (cnt_q == CW'(EXP_BITS));
`endif

    // Next-state and output decode for the exponentiation sequencer.
    always_comb begin
        state_d    = state_q;
        m_d        = m_q;
        t_d        = t_q;
        n_d        = n_q;
        d_d        = d_q;
        cnt_d      = cnt_q;
        res_d      = res_q;
        o_ma_start = 1'b0;
        o_ma_a     = '0;
        o_ma_b     = '0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    m_d     = WIDTH'(1);
                    t_d     = i_t;
                    n_d     = i_n;
                    d_d     = i_d;
                    cnt_d   = '0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (fin) begin
                    // Load the result register here so it is already valid during DONE.
                    res_d   = m_q;
                    state_d = DONE;
                end else if (d_q[0]) begin
                    state_d = MUL_REQ;
                end else begin
                    state_d = SQR_REQ;
                end
            end
            MUL_REQ: begin
                o_ma_start = 1'b1;
                o_ma_a     = m_q;
                o_ma_b     = t_q;
                state_d    = MUL_WAIT;
            end
            MUL_WAIT: begin
                o_ma_a = m_q;
                o_ma_b = t_q;
                if (i_ma_end) begin
                    m_d     = i_ma_result;
                    state_d = SQR_REQ;
                end
            end
            SQR_REQ: begin
                o_ma_start = 1'b1;
                o_ma_a     = t_q;
                o_ma_b     = t_q;
                state_d    = SQR_WAIT;
            end
            SQR_WAIT: begin
                o_ma_a = t_q;
                o_ma_b = t_q;
                if (i_ma_end) begin
                    t_d     = i_ma_result;
                    d_d     = d_q >> 1;
                    cnt_d   = cnt_q + CW'(1);
                    state_d = CHECK;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            m_q     <= '0;
            t_q     <= '0;
            n_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            t_q     <= t_d;
            n_q     <= n_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    assign o_busy   = (state_q != IDLE);
    assign o_done   = (state_q == DONE);
    assign o_result = res_q;
    assign o_ma_n   = n_q;

endmodule

// File: doc/rsa_exp_ctrl.md
# rsa_exp_ctrl

Sequencer that computes y^d mod n with right-to-left square-and-multiply. It time-shares a single external Montgomery multiplier (MontAlg) between the multiply and square steps. It sits between the RSA top-level control, which supplies n, d and the pre-transformed operand t = y·2^WIDTH mod n, and the MontAlg instance, whose start/end handshake and operand buses it drives directly.

## Interface
Parameters:
- WIDTH, 256, modulus/operand width in bits
- EXP_BITS, 256, exponent width in bits

Ports:
- i_clk  in  1  clock; all state changes on rising edge
- i_rst_n  in  1  synchronous active-low reset
- i_start  in  1  start request; sampled only in IDLE
- i_n  in  WIDTH  modulus; latched on accepted start
- i_t  in  WIDTH  y·2^WIDTH mod n (Montgomery form); latched on accepted start
- i_d  in  EXP_BITS  exponent; latched on accepted start
- o_busy  out  1  high from the cycle after an accepted start through the DONE cycle
- o_done  out  1  one-cycle completion pulse
- o_result  out  WIDTH  y^d mod n; valid from o_done, held until the next accepted start
- o_ma_start  out  1  one-cycle start pulse to MontAlg
- o_ma_n  out  WIDTH  latched modulus to MontAlg
- o_ma_a  out  WIDTH  MontAlg operand A
- o_ma_b  out  WIDTH  MontAlg operand B
- i_ma_result  in  WIDTH  MontAlg result
- i_ma_end  in  1  MontAlg completion pulse

## Operation
- Registers: m (WIDTH), t (WIDTH), n (WIDTH), d_sh (EXP_BITS), cnt (ceil(log2(EXP_BITS+1)) bits).
- Accepted start (IDLE && i_start): m←1, t←i_t, n←i_n, d_sh←i_d, cnt←0, state←CHECK.
- States:
  - IDLE → CHECK on accepted start.
  - CHECK → DONE if the termination condition holds (see Configuration). Otherwise → MUL_REQ if d_sh[0], else → SQR_REQ.
  - MUL_REQ: o_ma_start=1, a=m, b=t → MUL_WAIT.
  - MUL_WAIT: on i_ma_end, m←i_ma_result → SQR_REQ.
  - SQR_REQ: o_ma_start=1, a=t, b=t → SQR_WAIT.
  - SQR_WAIT: on i_ma_end, t←i_ma_result, d_sh←d_sh>>1, cnt←cnt+1 → CHECK.
  - DONE: o_done=1, o_result←m → IDLE.
- o_ma_a/o_ma_b hold stable from the *_REQ cycle until the cycle after the matching i_ma_end. They are 0 in IDLE/DONE. o_ma_n = latched n.
- Exactly one MontAlg operation is outstanding at any time. The multiply always precedes the square for the same bit.
- m and t are never reduced further. MontAlg output is treated as already in [0, n).

## Timing
- Reset (i_rst_n=0 at an edge), from any state, including mid-WAIT: state=IDLE, o_busy=0, o_done=0, o_ma_start=0, o_ma_a=o_ma_b=0, o_result=0, o_ma_n=0. Any MontAlg result arriving afterwards is ignored.
- Start accepted at edge k: o_busy=1 from cycle k+1. CHECK occupies cycle k+1.
- Each MontAlg operation costs 1 REQ cycle + MontAlg latency L + 1 cycle to return to the next state. The block is agnostic to L.
- Total cycles from accepted start to o_done = 2 + Σ_ops (L+2) + (number of CHECK visits after the first).
- i_start while not IDLE: ignored, no effect on latched operands.
- i_ma_end outside MUL_WAIT/SQR_WAIT: ignored.
- i_ma_end in the same cycle as REQ: ignored. The WAIT state samples only from the following cycle.
- i_start in the DONE cycle: ignored. It is accepted only once IDLE is re-entered.

## Configuration
- RSA_EXP_EARLY_EXIT_EN defined: CHECK terminates when d_sh == 0 (or cnt == EXP_BITS). Trailing zero exponent bits cost no MontAlg operations. d=0 completes with zero operations.
- Not defined: CHECK terminates only when cnt == EXP_BITS. Exactly EXP_BITS squarings plus popcount(d) multiplies are always issued, giving constant-count squaring independent of d's magnitude.

## Test plan
- Bench uses the real MontAlg, or a behavioral model with programmable L ∈ {1, 5, 258}. The bench computes t = y·2^256 mod n.
- n=3233, y=65, d=17 → o_result=2790. o_ma_start pulse count = 2 multiplies + 256 squares (macro off) or 2 + 5 (macro on).
- n=3233, y=2790, d=2753 → o_result=65. m and t are checked against a reference model after every i_ma_end.
- d=0, y=1234, n=3233 → o_result=1. With the macro on, o_done is high in cycle k+2 after start edge k, with no o_ma_start.
- i_start pulsed with new operands during SQR_WAIT → ignored; the result equals the original job. Spurious i_ma_end in CHECK → ignored.
- i_rst_n=0 for one edge during MUL_WAIT → the next cycle shows all outputs at reset values and state IDLE. The next start with d=17, y=65, n=3233 gives 2790.
